// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] IF_BUBBLE_INST   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_chk.sv
// Protocol checker for the fetch stage: every response must retire a request
// that is still outstanding (either a live queue entry or a wrong-path drop).
module if_fetch_chk #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          resp_valid,
  input logic [CW-1:0] drop_cnt,
  input logic [CW-1:0] unfilled_count
);

  a_resp_has_owner: assert property (@(posedge clk) disable iff (rst)
    resp_valid |-> ((|drop_cnt) || (|unfilled_count)));

endmodule

// File: rtl/if_fetch_queue.sv
// In-order fetch queue: entries are allocated when a request is accepted and
// filled in the same order as responses return; the head is presented to IF/ID.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    alloc,
  input  logic [31:0]             alloc_pc,
  input  logic                    fill,
  input  logic [31:0]             fill_inst,
  input  logic                    pop,
  output logic [31:0]             head_pc,
  output logic [31:0]             head_inst,
  output logic                    head_valid,
  output logic [$clog2(QDEPTH):0] count,
  output logic [$clog2(QDEPTH):0] unfilled_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] PTR_ZERO = {(PW + 1){1'b0}};
  localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};

  fetch_entry_t entries_q [QDEPTH];
  fetch_entry_t entries_d [QDEPTH];
  logic [PW:0]  head_q, head_d;
  logic [PW:0]  tail_q, tail_d;
  logic [PW:0]  fptr_q, fptr_d;
  fetch_entry_t head_entry;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fptr_d    = fptr_q;
    if (clear) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entries_d[i].filled = 1'b0;
      end
      head_d = PTR_ZERO;
      tail_d = PTR_ZERO;
      fptr_d = PTR_ZERO;
    end else begin
      if (alloc) begin
        entries_d[tail_q[PW-1:0]] = '{pc: alloc_pc, inst: IF_BUBBLE_INST, filled: 1'b0};
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (fill) begin
        entries_d[fptr_q[PW-1:0]].inst   = fill_inst;
        entries_d[fptr_q[PW-1:0]].filled = 1'b1;
        fptr_d = fptr_q + PTR_ONE;
      end else begin
        fptr_d = fptr_q;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entries_q[i] <= '{pc: 32'h0000_0000, inst: IF_BUBBLE_INST, filled: 1'b0};
      end
      head_q <= PTR_ZERO;
      tail_q <= PTR_ZERO;
      fptr_q <= PTR_ZERO;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fptr_q    <= fptr_d;
    end
  end

  // A popped slot keeps its stale filled bit, so gate validity on occupancy.
  always_comb begin
    head_entry     = entries_q[head_q[PW-1:0]];
    count          = tail_q - head_q;
    unfilled_count = tail_q - fptr_q;
    head_pc        = head_entry.pc;
    head_inst      = head_entry.inst;
    head_valid     = head_entry.filled && (count != PTR_ZERO);
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and
// discards wrong-path responses after a redirect. Optional trace: IF_TRACE_EN.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_id_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW - 1){1'b0}}, 1'b1};
  localparam logic [CW:0]   OUT_LIMIT = (CW + 1)'(QDEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] q_count, q_unfilled;
  logic [31:0]   q_head_pc, q_head_inst;
  logic          q_head_valid;
  logic [CW:0]   outstanding;
  logic          req_fire, resp_legal;
  logic          q_alloc, q_fill, q_pop, q_clear;

  if_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk           (clk),
    .rst           (rst),
    .clear         (q_clear),
    .alloc         (q_alloc),
    .alloc_pc      (fetch_pc_q),
    .fill          (q_fill),
    .fill_inst     (imem_resp_data),
    .pop           (q_pop),
    .head_pc       (q_head_pc),
    .head_inst     (q_head_inst),
    .head_valid    (q_head_valid),
    .count         (q_count),
    .unfilled_count(q_unfilled)
  );

  always_comb begin
    outstanding    = {1'b0, q_count} + {1'b0, drop_cnt_q};
    imem_req_valid = !rst && (outstanding < OUT_LIMIT);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_legal     = imem_resp_valid && ((drop_cnt_q != CNT_ZERO) || (q_unfilled != CNT_ZERO));
  end

  // On redirect a same-cycle response still retires one outstanding request,
  // so it offsets the unfilled entries and any same-cycle handshake being dropped.
  always_comb begin
    q_alloc    = 1'b0;
    q_fill     = 1'b0;
    q_pop      = 1'b0;
    q_clear    = 1'b0;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      q_clear    = 1'b1;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      drop_cnt_d = drop_cnt_q + q_unfilled + (req_fire ? CNT_ONE : CNT_ZERO)
                   - (resp_legal ? CNT_ONE : CNT_ZERO);
    end else begin
      q_alloc = req_fire;
      q_pop   = q_head_valid && !if_id_stall;
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (resp_legal && (drop_cnt_q != CNT_ZERO)) begin
        drop_cnt_d = drop_cnt_q - CNT_ONE;
      end else begin
        drop_cnt_d = drop_cnt_q;
        q_fill     = resp_legal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= CNT_ZERO;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    if_valid = q_head_valid;
    if (q_head_valid) begin
      if_pc   = q_head_pc;
      if_inst = q_head_inst;
    end else begin
      if_pc   = 32'h0000_0000;
      if_inst = IF_BUBBLE_INST;
    end
  end

  if_fetch_chk #(.CW(CW)) u_chk (
    .clk           (clk),
    .rst           (rst),
    .resp_valid    (imem_resp_valid),
    .drop_cnt      (drop_cnt_q),
    .unfilled_count(q_unfilled)
  );

`ifdef IF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && q_pop) begin
      $display("IF pc: %h inst: %h", if_pc, if_inst);
    end
    if (!rst && redirect_valid) begin
      $display("IF redirect -> %h drop %0d", fetch_pc_d, drop_cnt_d);
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with an in-order, 1-cycle imem model.
module tb_if_fetch_stage;

  logic        clk, rst, redirect_valid, if_id_stall;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid, if_valid;
  logic [31:0] redirect_pc, imem_req_addr, imem_resp_data, if_pc, if_inst;

  int          checks;
  int          failures;
  logic        auto_resp;
  logic [31:0] pend[$];
  logic [63:0] got[$];

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_stall    (if_id_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_valid       (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: memory answers the oldest accepted request one cycle later with
  // inst = 0x1300_0000 | addr; consumed {pc,inst} pairs are logged in got.
  task automatic tick();
    logic        hs;
    logic [31:0] hs_addr;
    if (auto_resp && pend.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h1300_0000 | pend[0];
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    if (if_valid && !if_id_stall && !redirect_valid && !rst) got.push_back({if_pc, if_inst});
    @(posedge clk);
    if (rst) begin
      pend.delete();
    end else begin
      if (imem_resp_valid) void'(pend.pop_front());
      if (hs) pend.push_back(hs_addr);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; if_id_stall = 1'b0;
    imem_req_ready = 1'b1; auto_resp = 1'b0;
    tick(); tick();
    rst = 1'b0; auto_resp = 1'b1;
    got.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
    checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h expected 0", if_inst); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL reset_release_req: got %b expected 1", imem_req_valid); end
  endtask

  task automatic test_basic();
    logic [63:0] exp_tab [3];
    exp_tab[0] = 64'h0000_0000_1300_0000;
    exp_tab[1] = 64'h0000_0004_1300_0004;
    exp_tab[2] = 64'h0000_0008_1300_0008;
    do_reset();
    tick();
    checks++; if (imem_req_addr !== 32'h4 || imem_req_valid !== 1'b1) begin failures++; $display("FAIL basic_issue1: got addr %h valid %b expected 4/1", imem_req_addr, imem_req_valid); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h1300_0000) begin failures++; $display("FAIL basic_first: got %b %h %h expected 1 0 13000000", if_valid, if_pc, if_inst); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL basic_full: got %b expected 0", imem_req_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'h1300_0004) begin failures++; $display("FAIL basic_second: got %b %h %h expected 1 4 13000004", if_valid, if_pc, if_inst); end
    checks++; if (imem_req_addr !== 32'h8 || imem_req_valid !== 1'b1) begin failures++; $display("FAIL basic_issue3: got addr %h valid %b expected 8/1", imem_req_addr, imem_req_valid); end
    for (int n = 0; n < 20 && got.size() < 3; n++) tick();
    checks++; if (got.size() != 3) begin failures++; $display("FAIL basic_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== exp_tab[i]) begin
        failures++; $display("FAIL basic_seq%0d: got %h expected %h", i, (got.size() > i) ? got[i] : 64'h0, exp_tab[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp_tab [4];
    exp_tab[0] = 64'h0000_0000_1300_0000;
    exp_tab[1] = 64'h0000_0004_1300_0004;
    exp_tab[2] = 64'h0000_0008_1300_0008;
    exp_tab[3] = 64'h0000_000C_1300_000C;
    do_reset();
    tick(); tick(); tick();
    if_id_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'h1300_0004) begin failures++; $display("FAIL stall_hold%0d: got %b %h %h expected 1 4 13000004", k, if_valid, if_pc, if_inst); end
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_backpressure%0d: got %b expected 0", k, imem_req_valid); end
    end
    if_id_stall = 1'b0;
    for (int n = 0; n < 20 && got.size() < 4; n++) tick();
    checks++; if (got.size() != 4) begin failures++; $display("FAIL stall_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== exp_tab[i]) begin
        failures++; $display("FAIL stall_seq%0d: got %h expected %h", i, (got.size() > i) ? got[i] : 64'h0, exp_tab[i]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    auto_resp = 1'b0;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got %b expected 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_limit: got %b expected 0", imem_req_valid); end
    auto_resp = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL redir_issue: got %b %h expected 1 100", imem_req_valid, imem_req_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_drop1: got %b expected 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_drop2: got %b expected 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h1300_0100) begin failures++; $display("FAIL redir_first: got %b %h %h expected 1 100 13000100", if_valid, if_pc, if_inst); end
    checks++; if (got.size() != 0) begin failures++; $display("FAIL redir_wrongpath: got %0d consumed expected 0", got.size()); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL same_addr: got %b %h expected 1 200", imem_req_valid, imem_req_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL same_flush: got %b expected 0", if_valid); end
    tick();
    checks++; if (imem_req_addr !== 32'h204 || if_valid !== 1'b0) begin failures++; $display("FAIL same_drop: got %h %b expected 204 0", imem_req_addr, if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== 32'h1300_0200) begin failures++; $display("FAIL same_first: got %b %h %h expected 1 200 13000200", if_valid, if_pc, if_inst); end
    checks++; if (got.size() != 0) begin failures++; $display("FAIL same_wrongpath: got %0d consumed expected 0", got.size()); end
  endtask

  task automatic test_ready_low();
    do_reset();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL ready_hold%0d: got %b %h expected 1 0", k, imem_req_valid, imem_req_addr); end
    end
    imem_req_ready = 1'b1;
    tick();
    checks++; if (imem_req_addr !== 32'h4) begin failures++; $display("FAIL ready_advance: got %h expected 4", imem_req_addr); end
    for (int n = 0; n < 20 && got.size() < 1; n++) tick();
    checks++; if (got.size() < 1 || got[0] !== 64'h0000_0000_1300_0000) begin failures++; $display("FAIL ready_first: got %h expected 0000000013000000", (got.size() > 0) ? got[0] : 64'h0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_resp = 1'b0;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL mid_pre: got %b expected 0", imem_req_valid); end
    rst = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin failures++; $display("FAIL mid_outputs: got %b %h %h expected 0 0 0", if_valid, if_pc, if_inst); end
    checks++; if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL mid_req: got %h %b expected 0 0", imem_req_addr, imem_req_valid); end
    rst = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL mid_dropclr: got %b %h expected 1 0", imem_req_valid, imem_req_addr); end
    auto_resp = 1'b1;
    got.delete();
    for (int n = 0; n < 20 && got.size() < 1; n++) tick();
    checks++; if (got.size() < 1 || got[0] !== 64'h0000_0000_1300_0000) begin failures++; $display("FAIL mid_first: got %h expected 0000000013000000", (got.size() > 0) ? got[0] : 64'h0); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; if_id_stall = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; auto_resp = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_ready_low();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
